// File: rtl/jtkicker_romresp_pkg.sv
// Shared types for the video ROM responder: fetch FSM encoding and client identifiers.
`timescale 1ns/1ps
package jtkicker_romresp_pkg;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_LO   = 2'd1,
    FSM_HI   = 2'd2,
    FSM_DONE = 2'd3
  } fsm_e;

  typedef enum logic {
    CLI_SCR = 1'b0,
    CLI_OBJ = 1'b1
  } client_e;

  localparam logic [1:0] ST_IDLE = FSM_IDLE;
  localparam logic [1:0] ST_LO   = FSM_LO;
  localparam logic [1:0] ST_HI   = FSM_HI;
  localparam logic [1:0] ST_DONE = FSM_DONE;

endpackage

// File: rtl/jtkicker_romresp_cache.sv
// One-word cache for a single ROM client: tag, 32-bit word, valid flag and the hit compare.
`timescale 1ns/1ps
module jtkicker_romresp_cache
  import jtkicker_romresp_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          en,
  input  logic          clr,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic          fill,
  input  logic [15:0]   din,
  input  logic [AW-1:0] ftag,
  output logic [31:0]   data,
  output logic          hit,
  output logic          miss
);

  logic [AW-1:0] tag_q, tag_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    // valid drops when the fill starts so a half-written word is never reported as a hit
    if (clr)   valid_d = 1'b0;
    if (wr_lo) data_d[15:0]  = din;
    if (wr_hi) data_d[31:16] = din;
    if (fill) begin
      tag_d   = ftag;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data = data_q;
  assign hit  = valid_q & en & (tag_q == addr);
  assign miss = en & ~hit;

endmodule

// File: rtl/jtkicker_gfx_romresp.sv
// Serves the scroll and object ROM clients from one 16-bit SDRAM read port, two reads per 32-bit word.
`timescale 1ns/1ps
module jtkicker_gfx_romresp
  import jtkicker_romresp_pkg::*;
#(
  parameter int                SCR_AW     = 13,
  parameter int                OBJ_AW     = 14,
  parameter int                MEM_AW     = 22,
  parameter logic [MEM_AW-1:0] SCR_OFFSET = 22'h0,
  parameter logic [MEM_AW-1:0] OBJ_OFFSET = 22'h8000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SCR_AW-1:0] scr_addr,
  output logic [31:0]       scr_data,
  output logic              scr_ok,
  input  logic              obj_cs,
  input  logic [OBJ_AW-1:0] obj_addr,
  output logic [31:0]       obj_data,
  output logic              obj_ok,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_rdy,
  input  logic [15:0]       mem_dout,
  output logic [1:0]        st_dbg
);

  // SDRAM handshake: mem_rd rises with mem_addr and is held (address advancing once) until the
  // second mem_rdy pulse; mem_dout is taken only in the cycle mem_rdy is high while in LO or HI.

  localparam int FAW = (SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW;

  logic [1:0]     st_q, st_d;
  logic           cli_q, cli_d;
  logic           rr_q, rr_d;
  logic [FAW-1:0] faddr_q, faddr_d;

  logic grant, gnt_obj, wr_lo, wr_hi, fill;
  logic scr_hit, scr_miss, obj_hit, obj_miss;
  logic [MEM_AW-1:0] base;

  always_comb begin
    st_d    = st_q;
    cli_d   = cli_q;
    rr_d    = rr_q;
    faddr_d = faddr_q;
    grant   = 1'b0;
    gnt_obj = 1'b0;
    wr_lo   = 1'b0;
    wr_hi   = 1'b0;
    fill    = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (scr_miss | obj_miss) begin
          // rr_q names the client preferred on a tie, i.e. the one not served last
          grant   = 1'b1;
          gnt_obj = obj_miss & (~scr_miss | (rr_q == CLI_OBJ));
          cli_d   = gnt_obj;
          rr_d    = ~gnt_obj;
          faddr_d = gnt_obj ? FAW'(obj_addr) : FAW'(scr_addr);
          st_d    = ST_LO;
        end
      end
      ST_LO: begin
        if (mem_rdy) begin
          wr_lo = 1'b1;
          st_d  = ST_HI;
        end
      end
      ST_HI: begin
        if (mem_rdy) begin
          wr_hi = 1'b1;
          st_d  = ST_DONE;
        end
      end
      default: begin
        fill = 1'b1;
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      cli_q   <= CLI_SCR;
      rr_q    <= CLI_SCR;
      faddr_q <= '0;
    end else begin
      st_q    <= st_d;
      cli_q   <= cli_d;
      rr_q    <= rr_d;
      faddr_q <= faddr_d;
    end
  end

  assign mem_rd   = (st_q == ST_LO) | (st_q == ST_HI);
  assign base     = (cli_q == CLI_OBJ) ? OBJ_OFFSET : SCR_OFFSET;
  assign mem_addr = mem_rd ? (base + MEM_AW'({faddr_q, 1'b0}) + MEM_AW'(st_q == ST_HI)) : '0;
  assign st_dbg   = st_q;

  jtkicker_romresp_cache #(.AW(SCR_AW)) u_scr_cache (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (scr_addr),
    .en    (1'b1),
    .clr   (grant & ~gnt_obj),
    .wr_lo (wr_lo & (cli_q == CLI_SCR)),
    .wr_hi (wr_hi & (cli_q == CLI_SCR)),
    .fill  (fill & (cli_q == CLI_SCR)),
    .din   (mem_dout),
    .ftag  (faddr_q[SCR_AW-1:0]),
    .data  (scr_data),
    .hit   (scr_hit),
    .miss  (scr_miss)
  );

  jtkicker_romresp_cache #(.AW(OBJ_AW)) u_obj_cache (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (obj_addr),
    .en    (obj_cs),
    .clr   (grant & gnt_obj),
    .wr_lo (wr_lo & (cli_q == CLI_OBJ)),
    .wr_hi (wr_hi & (cli_q == CLI_OBJ)),
    .fill  (fill & (cli_q == CLI_OBJ)),
    .din   (mem_dout),
    .ftag  (faddr_q[OBJ_AW-1:0]),
    .data  (obj_data),
    .hit   (obj_hit),
    .miss  (obj_miss)
  );

  assign scr_ok = scr_hit;
  assign obj_ok = obj_hit;

endmodule

// File: tb/tb_jtkicker_gfx_romresp.sv
// Directed bench for jtkicker_gfx_romresp with an SDRAM model that returns the low 16 address bits.
`timescale 1ns/1ps
module tb_jtkicker_gfx_romresp;
  import jtkicker_romresp_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic [12:0] scr_addr = '0;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs = 1'b0;
  logic [13:0] obj_addr = '0;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_rdy = 1'b0;
  logic [15:0] mem_dout = '0;
  logic [1:0]  st_dbg;

  int checks = 0;
  int failures = 0;
  int lat = 2;
  int cnt = 0;
  int fetch_cnt = 0;
  logic rd_prev = 1'b0;
  logic [21:0] exp_q[$];
  logic [21:0] rdy_q[$];
  logic        gnt_q[$];

  jtkicker_gfx_romresp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scr_addr (scr_addr),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdy  (mem_rdy),
    .mem_dout (mem_dout),
    .st_dbg   (st_dbg)
  );

  // SDRAM model: answers each held read after lat cycles, data = address
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 0;
      mem_rdy <= 1'b0;
    end else begin
      mem_rdy <= 1'b0;
      if (mem_rd && !mem_rdy) begin
        if (cnt >= lat - 1) begin
          mem_rdy  <= 1'b1;
          mem_dout <= mem_addr[15:0];
          cnt      <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // monitors: addresses accepted by the DUT, and the client of each new fetch
  always @(posedge clk) begin
    if (rst_n && mem_rd && mem_rdy) rdy_q.push_back(mem_addr);
  end

  always @(negedge clk) begin
    if (mem_rd && !rd_prev) begin
      fetch_cnt++;
      gnt_q.push_back(mem_addr >= 22'h8000);
    end
    rd_prev = mem_rd;
  end

  task automatic wait_state(input logic [1:0] s, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (st_dbg == s) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_scr_ok(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scr_ok) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_obj_ok(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obj_ok) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scr_addr = 13'h0010; obj_cs = 1'b0; obj_addr = '0; lat = 2;
    repeat (3) @(negedge clk);
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%0h exp=0", mem_rd); end
    checks++; if (mem_addr !== 22'h0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (scr_ok !== 1'b0) begin failures++; $display("FAIL reset_scr_ok got=%0h exp=0", scr_ok); end
    checks++; if (obj_ok !== 1'b0) begin failures++; $display("FAIL reset_obj_ok got=%0h exp=0", obj_ok); end
    checks++; if (scr_data !== 32'h0) begin failures++; $display("FAIL reset_scr_data got=%0h exp=0", scr_data); end
    checks++; if (obj_data !== 32'h0) begin failures++; $display("FAIL reset_obj_data got=%0h exp=0", obj_data); end
    checks++; if (st_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0h exp=0", st_dbg); end
  endtask

  task automatic test_scroll_fill();
    bit got;
    bit bad;
    rdy_q.delete();
    exp_q = {22'h20, 22'h21};
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL fill_latency_rd got=%0h exp=1", mem_rd); end
    checks++; if (mem_addr !== 22'h20) begin failures++; $display("FAIL fill_lo_addr got=%0h exp=20", mem_addr); end
    checks++; if (scr_ok !== 1'b0) begin failures++; $display("FAIL fill_ok_early got=%0h exp=0", scr_ok); end
    wait_scr_ok(50, got);
    checks++; if (!got) begin failures++; $display("FAIL fill_timeout got=0 exp=1"); end
    checks++; if (scr_data !== 32'h0021_0020) begin failures++; $display("FAIL fill_scr_data got=%0h exp=00210020", scr_data); end
    bad = (rdy_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (rdy_q[i] !== exp_q[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL fill_addr_seq got=%p exp=%p", rdy_q, exp_q); end
  endtask

  task automatic test_both_miss();
    bit got;
    bit bad;
    rst_n = 1'b0; scr_addr = 13'h0030; obj_addr = 14'h0100; obj_cs = 1'b1;
    repeat (2) @(negedge clk);
    rdy_q.delete();
    exp_q = {22'h60, 22'h61, 22'h8200, 22'h8201};
    rst_n = 1'b1;
    wait_obj_ok(100, got);
    checks++; if (!got) begin failures++; $display("FAIL both_timeout got=0 exp=1"); end
    checks++; if (scr_ok !== 1'b1) begin failures++; $display("FAIL both_scr_ok got=%0h exp=1", scr_ok); end
    checks++; if (scr_data !== 32'h0061_0060) begin failures++; $display("FAIL both_scr_data got=%0h exp=00610060", scr_data); end
    checks++; if (obj_data !== 32'h8201_8200) begin failures++; $display("FAIL both_obj_data got=%0h exp=82018200", obj_data); end
    bad = (rdy_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (rdy_q[i] !== exp_q[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL both_order got=%p exp=%p", rdy_q, exp_q); end
  endtask

  task automatic test_addr_change();
    bit got;
    bit bad;
    int stale = 0;
    rdy_q.delete();
    exp_q = {22'h20, 22'h21, 22'h22, 22'h23};
    scr_addr = 13'h0010;
    wait_state(ST_HI, 50, got);
    checks++; if (!got) begin failures++; $display("FAIL chg_hi_timeout got=0 exp=1"); end
    scr_addr = 13'h0011;
    wait_state(ST_IDLE, 50, got);
    checks++; if (!got) begin failures++; $display("FAIL chg_done_timeout got=0 exp=1"); end
    checks++; if (scr_ok !== 1'b0) begin failures++; $display("FAIL chg_stale_ok got=%0h exp=0", scr_ok); end
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (scr_ok) begin
        got = 1'b1;
        if (scr_data !== 32'h0023_0022) stale++;
        break;
      end
    end
    checks++; if (!got) begin failures++; $display("FAIL chg_timeout got=0 exp=1"); end
    checks++; if (stale != 0 || scr_data !== 32'h0023_0022) begin failures++; $display("FAIL chg_scr_data got=%0h exp=00230022", scr_data); end
    bad = (rdy_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (rdy_q[i] !== exp_q[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL chg_addr_seq got=%p exp=%p", rdy_q, exp_q); end
  endtask

  task automatic test_obj_cs();
    bit got;
    int n0;
    int drops = 0;
    obj_cs = 1'b0; obj_addr = 14'h0200;
    repeat (3) @(negedge clk);
    n0 = fetch_cnt;
    repeat (10) @(negedge clk);
    checks++; if (fetch_cnt != n0) begin failures++; $display("FAIL cs_low_fetch got=%0d exp=%0d", fetch_cnt, n0); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL cs_low_rd got=%0h exp=0", mem_rd); end
    checks++; if (obj_ok !== 1'b0) begin failures++; $display("FAIL cs_low_ok got=%0h exp=0", obj_ok); end
    obj_cs = 1'b1;
    wait_obj_ok(50, got);
    checks++; if (!got) begin failures++; $display("FAIL cs_timeout got=0 exp=1"); end
    checks++; if (obj_data !== 32'h8401_8400) begin failures++; $display("FAIL cs_obj_data got=%0h exp=84018400", obj_data); end
    repeat (20) begin
      @(negedge clk);
      if (!obj_ok) drops++;
    end
    checks++; if (drops != 0) begin failures++; $display("FAIL cs_hold_ok got=%0d exp=0", drops); end
    checks++; if (fetch_cnt != n0 + 1) begin failures++; $display("FAIL cs_fetch_count got=%0d exp=%0d", fetch_cnt, n0 + 1); end
  endtask

  task automatic test_reset_mid();
    bit got;
    bit bad;
    scr_addr = 13'h0050;
    wait_state(ST_LO, 20, got);
    checks++; if (!got) begin failures++; $display("FAIL rst_lo_timeout got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rst_async_rd got=%0h exp=0", mem_rd); end
    checks++; if (scr_ok !== 1'b0) begin failures++; $display("FAIL rst_async_scr_ok got=%0h exp=0", scr_ok); end
    checks++; if (obj_ok !== 1'b0) begin failures++; $display("FAIL rst_async_obj_ok got=%0h exp=0", obj_ok); end
    checks++; if (st_dbg !== ST_IDLE) begin failures++; $display("FAIL rst_async_state got=%0h exp=0", st_dbg); end
    repeat (2) @(negedge clk);
    rdy_q.delete();
    exp_q = {22'hA0, 22'hA1, 22'h8400, 22'h8401};
    rst_n = 1'b1;
    wait_obj_ok(100, got);
    checks++; if (!got) begin failures++; $display("FAIL rst_refetch_timeout got=0 exp=1"); end
    checks++; if (scr_data !== 32'h00A1_00A0) begin failures++; $display("FAIL rst_scr_data got=%0h exp=00a100a0", scr_data); end
    checks++; if (obj_data !== 32'h8401_8400) begin failures++; $display("FAIL rst_obj_data got=%0h exp=84018400", obj_data); end
    bad = (rdy_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (rdy_q[i] !== exp_q[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL rst_refetch_seq got=%p exp=%p", rdy_q, exp_q); end
  endtask

  task automatic test_back_to_back();
    int si = 0;
    int oi = 0;
    int reqs = 0;
    int cyc = 0;
    int alt_bad = 0;
    int b;
    logic [31:0] exp_w;
    lat = 1;
    @(negedge clk);
    gnt_q.delete();
    scr_addr = 13'h0100;
    obj_addr = 14'h0300;
    while (reqs < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (scr_ok) begin
        b = 2 * (32'h100 + si);
        exp_w = {16'(b + 1), 16'(b)};
        checks++; if (scr_data !== exp_w) begin failures++; $display("FAIL b2b_scr_data got=%0h exp=%0h", scr_data, exp_w); end
        reqs++; si++;
        scr_addr = 13'(32'h100 + si);
      end
      if (obj_ok) begin
        b = 32'h8000 + 2 * (32'h300 + oi);
        exp_w = {16'(b + 1), 16'(b)};
        checks++; if (obj_data !== exp_w) begin failures++; $display("FAIL b2b_obj_data got=%0h exp=%0h", obj_data, exp_w); end
        reqs++; oi++;
        obj_addr = 14'(32'h300 + oi);
      end
    end
    checks++; if (reqs < 1000) begin failures++; $display("FAIL b2b_timeout got=%0d exp=1000", reqs); end
    for (int i = 1; i < gnt_q.size(); i++) if (gnt_q[i] == gnt_q[i-1]) alt_bad++;
    checks++; if (alt_bad != 0) begin failures++; $display("FAIL b2b_alternate got=%0d exp=0", alt_bad); end
    checks++; if (gnt_q.size() < 1000) begin failures++; $display("FAIL b2b_grant_count got=%0d exp=1000", gnt_q.size()); end
  endtask

  initial begin
    test_reset();
    test_scroll_fill();
    test_both_miss();
    test_addr_change();
    test_obj_cs();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
